// File: rtl/data_memory_line_ctrl.sv
// Off-chip data memory model plus its line controller: serves whole cache-line
// reads and writes behind an enable/write/ack handshake with a fixed latency.
module data_memory_line_ctrl #(
    parameter int LINE_W  = 256,
    parameter int ADDR_W  = 32,
    parameter int DEPTH   = 512,
    parameter int LATENCY = 10
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [LINE_W-1:0] data_i,
    input  logic              enable_i,
    input  logic              write_i,
    output logic              ack_o,
    output logic [LINE_W-1:0] data_o
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(LATENCY);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY - 2);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACK
    } state_t;

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [IDX_W-1:0]  idx_reg, idx_next;
    logic [LINE_W-1:0] wdata_reg, wdata_next;
    logic              wr_reg, wr_next;
    logic              ack_reg, ack_next;
    logic [LINE_W-1:0] rdata_reg;
    logic              done;

    // Line storage; deliberately has no reset so contents survive it.
    logic [LINE_W-1:0] mem [DEPTH];

    // Byte-offset bits and bits above the line index play no part in addressing.
    logic unused_addr;
    assign unused_addr = ^{addr_i[ADDR_W-1:5+IDX_W], addr_i[4:0]};

    assign done = (state_reg == WAIT) && (cnt_reg == CNT_LAST);

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        idx_next   = idx_reg;
        wdata_next = wdata_reg;
        wr_next    = wr_reg;
        ack_next   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (enable_i) begin
                    idx_next   = addr_i[5 +: IDX_W];
                    wdata_next = data_i;
                    wr_next    = write_i;
                    cnt_next   = '0;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                cnt_next = cnt_reg + 1'b1;
                if (done) begin
                    state_next = ACK;
                    ack_next   = 1'b1;
                end
            end
            // Guard cycle: the requester's enable is still high here and must not
            // start a second transaction.
            ACK: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            idx_reg   <= '0;
            wdata_reg <= '0;
            wr_reg    <= 1'b0;
            ack_reg   <= 1'b0;
            rdata_reg <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            idx_reg   <= idx_next;
            wdata_reg <= wdata_next;
            wr_reg    <= wr_next;
            ack_reg   <= ack_next;
            if (done && !wr_reg)
                rdata_reg <= mem[idx_reg];
        end
    end

    // Writes commit only on the ack edge; a reset puts the FSM in IDLE, so an
    // aborted write never reaches the array.
    always_ff @(posedge clk_i) begin
        if (done && wr_reg)
            mem[idx_reg] <= wdata_reg;
    end

    assign ack_o  = ack_reg;
    assign data_o = rdata_reg;

endmodule

// File: doc/data_memory_line_ctrl.md
Name: data_memory_line_ctrl

Overview:
- Off-chip data memory model with its controller, sitting directly downstream of the data cache (dcache_top) in the CPU.
- Serves whole 256-bit cache-line reads and writes over the enable/write/ack handshake.
- Each request waits a fixed multi-cycle latency, then completes with a one-cycle ack.
- CPU pipeline stalls come from the cache, which waits on this ack.

Parameters:
LINE_W, 256, line width in bits (one cache line)
ADDR_W, 32, byte address width
DEPTH, 512, number of lines stored; power of two
LATENCY, 10, cycles from request acceptance to ack; must be >= 2

Ports:
clk_i  input  1  clock, all state updates on rising edge
rst_i  input  1  asynchronous, active-low reset
addr_i  input  ADDR_W  byte address of line; bits [4:0] ignored
data_i  input  LINE_W  write line data
enable_i  input  1  request valid; requester holds it until ack_o
write_i  input  1  1 = write, 0 = read; qualified by enable_i
ack_o  output  1  one-cycle completion pulse
data_o  output  LINE_W  read line data, valid while ack_o = 1 for a read

Behaviour:
- Line index is addr[5 +: log2(DEPTH)].
  - Higher address bits are ignored, so addresses alias modulo DEPTH lines.
- Storage is an internal array mem[DEPTH] of LINE_W bits.
  - It is not cleared by reset; its contents are retained across reset.
  - The bench preloads it hierarchically.
- Reset (rst_i = 0, asynchronous):
  - state = IDLE, counter = 0, ack_o = 0, data_o = 0.
  - Latched address, data and write flag are cleared to 0.
- State machine, all outputs registered:
  - IDLE:
    - enable_i = 1 at an edge (edge E0): latch addr_i, data_i and write_i; counter = 0; go to WAIT.
    - Otherwise stay in IDLE.
  - WAIT:
    - Each edge increments counter. enable_i, write_i, addr_i and data_i are ignored; the inputs latched at E0 are used.
    - At the edge where counter == LATENCY-2 → go to ACK and set ack_o = 1.
    - At that same edge, for a read, data_o = mem[idx].
    - At that same edge, for a write, mem[idx] = latched data; data_o is unchanged.
    - Net timing: ack_o rises after edge E(LATENCY-1) and is high during cycle LATENCY counted from E0.
  - ACK:
    - The next edge clears ack_o and goes to IDLE. enable_i is ignored in this state.
    - This guard cycle prevents the still-asserted enable of the completed request from being accepted twice.
- Request throughput:
  - Earliest next acceptance is edge E(LATENCY+1).
  - Completed requests are therefore spaced at least LATENCY+1 cycles apart.
- data_o holds the last read line until the next read completes; writes and idle cycles do not change it.
- Read-after-write to the same line returns the newly written data, because the write commits at its ack edge.
- Reset during WAIT or ACK:
  - The request is aborted and a pending write is not committed.
  - ack_o drops immediately (asynchronously).
  - After reset releases, the block is in IDLE and an asserted enable_i is treated as a new request.
- counter width is clog2(LATENCY); it never wraps because the WAIT exit occurs first.
- No error reporting: every accepted request completes with exactly one ack.

Test Plan:
- Reset then read: preload mem[3] = {8{32'hA5A5_0003}}; hold enable_i = 1, write_i = 0, addr_i = 32'h60 from edge E0.
  → ack_o = 1 exactly during cycle 10 after E0, data_o = preload value, then ack_o = 0 next cycle.
- Write then read: write {8{32'hDEAD_BEEF}} to addr 32'h80 → one ack pulse, data_o unchanged.
  Then read 32'h80 → data_o = {8{32'hDEAD_BEEF}}.
- Held enable across ack: keep enable_i = 1 continuously for a single read.
  → a second acceptance occurs only at E11, and the second ack appears 21 cycles after E0; never ack in consecutive cycles.
- Aliasing and ignored low bits: write to 32'h0000_0020, read 32'h0000_403F (DEPTH = 512).
  → read returns the written line.
- Input change during WAIT: accept read of 32'h40; at cycle 4 switch addr_i to 32'h100 and write_i to 1.
  → ack returns mem[2], and mem[8] is unmodified.
- Reset mid-write: accept write to 32'hC0; assert rst_i = 0 at cycle 5 for 2 cycles.
  → ack_o = 0, data_o = 0, and mem[6] retains its old value.
  After reset releases with enable_i = 0, no ack occurs.
